w_sparse_buf: RTL

Per-head sparse weight buffer that sits directly upstream of each head's Q/K/V weight channel in the transformer. It accepts a dense 512x64 weight matrix as a stream of DENSE_NUM-wide beats, compresses every group of 16 consecutive weights into an 8-slot value word plus a 16-bit nonzero bitmap, and stores the result in a 2048-entry buffer. It raises `w_ok` once all 2048 entries are written, then serves the head's `w_cs`/`w_ren`/`w_rd_addr` reads with `w`/`w_bit_map`. One instance exists per head per channel (Q, K, V).

---
 rtl/w_sparse_pkg.sv | 22 ++
 rtl/w_sparse_buf_if.sv | 46 ++++
 rtl/w_sparse_mem.sv | 36 +++
 rtl/w_sparse_buf.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/w_sparse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : w_sparse_pkg
// Brief    : Shared constants and FSM encoding for the per-head sparse weight buffer.
// Revision : 1.0 - initial release
// ============================================================================
package w_sparse_pkg;
  localparam int GROUP_SZ  = 16;
  localparam int SLOT_NUM  = 8;
  localparam int BEAT_NUM  = 4;
  localparam int BMAP_W    = 16;
  localparam int SLOT_CW   = $clog2(SLOT_NUM + 1);
  localparam int BEAT_CW   = $clog2(BEAT_NUM);
  localparam int OVF_CNT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/w_sparse_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : w_sparse_buf_if
// Brief    : Load stream, read port and status bundle of w_sparse_buf.
//            W_SPARSE_STATS_EN adds the ovf_cnt group-overflow counter.
// Revision : 1.0 - initial release
// ============================================================================
interface w_sparse_buf_if
  import w_sparse_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DENSE_NUM  = 4,
  parameter int ADDR_W     = 11
);
  logic                            load_start;
  logic                            in_vld;
  logic                            in_rdy;
  logic [DENSE_NUM*DATA_WIDTH-1:0] in_data;
  logic                            w_ok;
  logic                            w_cs;
  logic                            w_ren;
  logic [ADDR_W-1:0]               w_rd_addr;
  logic [SLOT_NUM*DATA_WIDTH-1:0]  w;
  logic [BMAP_W-1:0]               w_bit_map;
  logic                            ovf_err;
`ifdef W_SPARSE_STATS_EN
  logic [OVF_CNT_W-1:0]            ovf_cnt;
`endif

  modport master (
    output load_start, in_vld, in_data, w_cs, w_ren, w_rd_addr,
    input  in_rdy, w_ok, w, w_bit_map, ovf_err
`ifdef W_SPARSE_STATS_EN
    , input ovf_cnt
`endif
  );

  modport slave (
    input  load_start, in_vld, in_data, w_cs, w_ren, w_rd_addr,
    output in_rdy, w_ok, w, w_bit_map, ovf_err
`ifdef W_SPARSE_STATS_EN
    , output ovf_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/w_sparse_mem.sv
`default_nettype none
// ============================================================================
// Module   : w_sparse_mem
// Brief    : Single-clock RAM, one write port and one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module w_sparse_mem #(
  parameter int WIDTH  = 144,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_wr_en,
  input  wire logic [ADDR_W-1:0] i_wr_addr,
  input  wire logic [WIDTH-1:0]  i_wr_data,
  input  wire logic              i_rd_en,
  input  wire logic [ADDR_W-1:0] i_rd_addr,
  output logic      [WIDTH-1:0]  o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Only the output register is reset; the array stays uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule
`default_nettype wire

// File: rtl/w_sparse_buf.sv
`default_nettype none
// ============================================================================
// Module   : w_sparse_buf
// Brief    : Compresses a dense weight stream into 8-slot + bitmap entries and
//            serves registered reads. W_SPARSE_STATS_EN adds ovf_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module w_sparse_buf
  import w_sparse_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DENSE_NUM  = 4,
  parameter int DEPTH      = 2048,
  parameter int ADDR_W     = 11
) (
  input wire logic      clk,
  input wire logic      rst_n,
  w_sparse_buf_if.slave bus
);
  localparam int c_WORD_W = SLOT_NUM * DATA_WIDTH;
  localparam int c_ENTRY_W = BMAP_W + c_WORD_W;

  state_t               r_state;
  logic                 r_in_rdy;
  logic                 r_w_ok;
  logic                 r_ovf_err;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [BEAT_CW-1:0]   r_beat_cnt;
  logic [SLOT_CW-1:0]   r_slot_cnt;
  logic [c_WORD_W-1:0]  r_stage;
  logic [BMAP_W-1:0]    r_bmap;

  logic [c_WORD_W-1:0]  w_stage_nxt;
  logic [BMAP_W-1:0]    w_bmap_nxt;
  logic [SLOT_CW-1:0]   w_slot_nxt;
  logic                 w_drop;
  logic                 w_acc;
  logic                 w_last_beat;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [c_ENTRY_W-1:0] w_rd_data;

  // Lanes are compacted in ascending order, so kept values are the lowest-index nonzeros.
  always_comb begin
    w_stage_nxt = r_stage;
    w_bmap_nxt  = r_bmap;
    w_slot_nxt  = r_slot_cnt;
    w_drop      = 1'b0;
    for (int j = 0; j < DENSE_NUM; j++) begin
      if (bus.in_data[j*DATA_WIDTH +: DATA_WIDTH] != '0) begin
        if (w_slot_nxt < SLOT_CW'(SLOT_NUM)) begin
          w_stage_nxt[int'(w_slot_nxt)*DATA_WIDTH +: DATA_WIDTH] = bus.in_data[j*DATA_WIDTH +: DATA_WIDTH];
          w_bmap_nxt[int'(r_beat_cnt)*DENSE_NUM + j] = 1'b1;
          w_slot_nxt = w_slot_nxt + SLOT_CW'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  assign w_acc       = bus.in_vld & r_in_rdy & ~bus.load_start;
  assign w_last_beat = (r_beat_cnt == BEAT_CW'(BEAT_NUM - 1));
  assign w_wr_en     = w_acc & w_last_beat;
  assign w_rd_en     = bus.w_cs & bus.w_ren & r_w_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_rdy   <= 1'b0;
      r_w_ok     <= 1'b0;
      r_ovf_err  <= 1'b0;
      r_wr_addr  <= '0;
      r_beat_cnt <= '0;
      r_slot_cnt <= '0;
      r_stage    <= '0;
      r_bmap     <= '0;
    end else if (bus.load_start) begin
      r_state    <= ST_LOAD;
      r_in_rdy   <= 1'b1;
      r_w_ok     <= 1'b0;
      r_ovf_err  <= 1'b0;
      r_wr_addr  <= '0;
      r_beat_cnt <= '0;
      r_slot_cnt <= '0;
      r_stage    <= '0;
      r_bmap     <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_acc) begin
            if (w_drop) r_ovf_err <= 1'b1;
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              r_slot_cnt <= '0;
              r_stage    <= '0;
              r_bmap     <= '0;
              r_wr_addr  <= r_wr_addr + ADDR_W'(1);
              if (r_wr_addr == ADDR_W'(DEPTH - 1)) begin
                r_state  <= ST_READY;
                r_in_rdy <= 1'b0;
                r_w_ok   <= 1'b1;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + BEAT_CW'(1);
              r_slot_cnt <= w_slot_nxt;
              r_stage    <= w_stage_nxt;
              r_bmap     <= w_bmap_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef W_SPARSE_STATS_EN
  logic                 r_grp_drop;
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp_drop <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (bus.load_start) begin
      r_grp_drop <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (w_acc) begin
      if (w_last_beat) begin
        r_grp_drop <= 1'b0;
        if (r_grp_drop | w_drop) r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
      end else if (w_drop) begin
        r_grp_drop <= 1'b1;
      end
    end
  end

  assign bus.ovf_cnt = r_ovf_cnt;
`endif

  w_sparse_mem #(
    .WIDTH  (c_ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_addr),
    .i_wr_data ({w_bmap_nxt, w_stage_nxt}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (bus.w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign bus.in_rdy    = r_in_rdy;
  assign bus.w_ok      = r_w_ok;
  assign bus.ovf_err   = r_ovf_err;
  assign bus.w         = w_rd_data[c_WORD_W-1:0];
  assign bus.w_bit_map = w_rd_data[c_ENTRY_W-1:c_WORD_W];
endmodule
`default_nettype wire
